// File: rtl/bus_pkg.sv
// Shared constants for the datapath bus arbiter: arbitration modes, default
// width and the legacy source index map.
package bus_pkg;
  localparam int MODE_FIXED    = 0;
  localparam int MODE_RR       = 1;
  localparam int DEFAULT_WIDTH = 32;

  localparam int SRC_PC     = 0;
  localparam int SRC_ZHIGH  = 1;
  localparam int SRC_ZLOW   = 2;
  localparam int SRC_MDR    = 3;
  localparam int SRC_R0     = 4;
  localparam int SRC_R15    = 19;
  localparam int SRC_HI     = 20;
  localparam int SRC_LO     = 21;
  localparam int SRC_Y      = 22;
  localparam int SRC_INPORT = 23;
  localparam int SRC_CSIGN  = 24;
  localparam int SRC_COUNT  = 25;

  // Bus index of general-purpose register Rn.
  function automatic int reg_src(input int n);
    return SRC_R0 + n;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority picker: first eligible request after start,
// wrapping modulo NUM_SRC. start = NUM_SRC-1 gives plain lowest-index priority.
module rr_priority_pick #(
  parameter int NUM_SRC = 25,
  parameter int IW      = 5
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      start,
  input  logic [NUM_SRC-1:0] exclude,
  output logic [NUM_SRC-1:0] win_oh,
  output logic [IW-1:0]      win_idx,
  output logic               win_any
);
  logic [NUM_SRC-1:0] elig;
  logic [IW-1:0]      pos;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    pos     = '0;
    elig    = req & ~exclude;
    for (int k = 1; k <= NUM_SRC; k++) begin
      pos = IW'((int'(start) + k) % NUM_SRC);
      if (!win_any && elig[pos]) begin
        win_any     = 1'b1;
        win_oh[pos] = 1'b1;
        win_idx     = pos;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered bus multiplexer with fixed-priority or round-robin arbitration,
// burst hold limiting and multi-request conflict logging.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int NUM_SRC   = SRC_COUNT,
  parameter int MODE      = MODE_FIXED,
  parameter int HOLD_MAX  = 4,
  parameter int IDLE_HOLD = 0
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic                       conflict_clr,
  output logic [NUM_SRC-1:0]         grant,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_valid,
  output logic                       conflict,
  output logic [7:0]                 conflict_cnt
);
  localparam int IW = $clog2(NUM_SRC);
  localparam logic [7:0] HM = 8'(HOLD_MAX);

  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WIDTH-1:0]   bus_q, bus_d;
  logic               valid_q, valid_d;
  logic               conf_q, conf_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]         hold_q, hold_d;

  logic               owner_req, others, keep, multi;
  logic [NUM_SRC-1:0] exclude;
  logic [IW-1:0]      start;
  logic [NUM_SRC-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_any;

  assign owner_req = valid_q && src_req[idx_q];
  assign others    = |(src_req & ~grant_q);
  // Owner stays while under its hold budget, or indefinitely when uncontested.
  assign keep      = owner_req && ((hold_q < HM) || !others);
  assign exclude   = (owner_req && !keep) ? grant_q : '0;
  assign start     = (MODE == MODE_RR) ? rr_ptr_q : IW'(NUM_SRC - 1);
  assign multi     = |(src_req & (src_req - 1'b1));

  rr_priority_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
    .req     (src_req),
    .start   (start),
    .exclude (exclude),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  always_comb begin
    grant_d  = grant_q;
    idx_d    = idx_q;
    bus_d    = bus_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    if (src_req == '0) begin
      grant_d = '0;
      valid_d = 1'b0;
      hold_d  = '0;
      if (IDLE_HOLD == 0) bus_d = '0;
    end else if (keep) begin
      bus_d  = src_data[int'(idx_q)*WIDTH +: WIDTH];
      hold_d = (hold_q < HM) ? hold_q + 8'd1 : HM;
    end else if (win_any) begin
      grant_d  = win_oh;
      idx_d    = win_idx;
      valid_d  = 1'b1;
      bus_d    = src_data[int'(win_idx)*WIDTH +: WIDTH];
      rr_ptr_d = win_idx;
      hold_d   = 8'd1;
    end
  end

  // A conflict in the clearing cycle still counts as the first one.
  always_comb begin
    conf_d = conf_q;
    cnt_d  = cnt_q;
    if (conflict_clr) begin
      conf_d = multi;
      cnt_d  = multi ? 8'd1 : 8'd0;
    end else if (multi) begin
      conf_d = 1'b1;
      cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      grant_q  <= '0;
      idx_q    <= '0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
      conf_q   <= 1'b0;
      cnt_q    <= '0;
      rr_ptr_q <= IW'(NUM_SRC - 1);
      hold_q   <= '0;
    end else begin
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      conf_q   <= conf_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign grant        = grant_q;
  assign grant_idx    = idx_q;
  assign bus_out      = bus_q;
  assign bus_valid    = valid_q;
  assign conflict     = conf_q;
  assign conflict_cnt = cnt_q;

  a_onehot: assert property (@(posedge clock) $onehot0(grant_q));
  a_valid:  assert property (@(posedge clock) bus_valid == (|grant_q));
  a_idx:    assert property (@(posedge clock) !bus_valid || grant_q[idx_q]);
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: a fixed-priority instance (HOLD_MAX=4,
// IDLE_HOLD=0) and a round-robin instance (HOLD_MAX=1, IDLE_HOLD=1) share stimulus.
module tb_bus_arbiter_mux;
  localparam int W = 32;
  localparam int N = 25;

  logic           clock = 1'b0;
  logic           clear;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_req;
  logic           conflict_clr;

  logic [N-1:0] a_grant, b_grant;
  logic [4:0]   a_idx, b_idx;
  logic [W-1:0] a_bus, b_bus;
  logic         a_valid, b_valid, a_conf, b_conf;
  logic [7:0]   a_cnt, b_cnt;

  int chk  = 0;
  int pass = 0;

  always #5 clock = ~clock;

  bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(0), .HOLD_MAX(4), .IDLE_HOLD(0)) dut_a (
    .clock(clock), .clear(clear), .src_data(src_data), .src_req(src_req),
    .conflict_clr(conflict_clr), .grant(a_grant), .grant_idx(a_idx), .bus_out(a_bus),
    .bus_valid(a_valid), .conflict(a_conf), .conflict_cnt(a_cnt)
  );

  bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(1), .HOLD_MAX(1), .IDLE_HOLD(1)) dut_b (
    .clock(clock), .clear(clear), .src_data(src_data), .src_req(src_req),
    .conflict_clr(conflict_clr), .grant(b_grant), .grant_idx(b_idx), .bus_out(b_bus),
    .bus_valid(b_valid), .conflict(b_conf), .conflict_cnt(b_cnt)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; src_req = '1; conflict_clr = 1'b0;
    step(); step();
    chk++; if ({a_grant, a_idx, a_bus, a_valid, a_conf, a_cnt} !== '0)
      $display("FAIL rst_a outputs got grant=%h idx=%0d bus=%h v=%b c=%b cnt=%0d exp all zero", a_grant, a_idx, a_bus, a_valid, a_conf, a_cnt); else pass++;
    chk++; if ({b_grant, b_idx, b_bus, b_valid, b_conf, b_cnt} !== '0)
      $display("FAIL rst_b outputs got grant=%h idx=%0d bus=%h v=%b c=%b cnt=%0d exp all zero", b_grant, b_idx, b_bus, b_valid, b_conf, b_cnt); else pass++;
    clear = 1'b0;
    step();
    chk++; if (a_grant !== 25'h1 || a_idx !== 5'd0 || a_valid !== 1'b1)
      $display("FAIL rel_a_grant got grant=%h idx=%0d v=%b exp grant=1 idx=0 v=1", a_grant, a_idx, a_valid); else pass++;
    chk++; if (a_bus !== 32'hA000_0000)
      $display("FAIL rel_a_bus got %h exp a0000000", a_bus); else pass++;
    chk++; if (b_grant !== 25'h1 || b_bus !== 32'hA000_0000)
      $display("FAIL rel_b got grant=%h bus=%h exp grant=1 bus=a0000000", b_grant, b_bus); else pass++;
    chk++; if (a_conf !== 1'b1 || a_cnt !== 8'd1)
      $display("FAIL rel_a_conflict got c=%b cnt=%0d exp c=1 cnt=1", a_conf, a_cnt); else pass++;
    src_req = '0; conflict_clr = 1'b1;
    step();
    conflict_clr = 1'b0;
  endtask

  task automatic test_single();
    src_data[3*W +: W] = 32'hDEAD_BEEF;
    src_req = 25'h1 << 3;
    step();
    chk++; if (a_bus !== 32'hDEAD_BEEF || a_grant !== (25'h1 << 3) || a_conf !== 1'b0)
      $display("FAIL single_a got bus=%h grant=%h c=%b exp deadbeef/%h/0", a_bus, a_grant, a_conf, 25'h1 << 3); else pass++;
    chk++; if (b_bus !== 32'hDEAD_BEEF || b_idx !== 5'd3)
      $display("FAIL single_b got bus=%h idx=%0d exp deadbeef/3", b_bus, b_idx); else pass++;
    src_req = '0;
    step();
    chk++; if (a_valid !== 1'b0 || a_bus !== '0)
      $display("FAIL idle_a got v=%b bus=%h exp 0/0", a_valid, a_bus); else pass++;
  endtask

  task automatic test_burst();
    int exp_idx[12] = '{5, 5, 5, 5, 2, 2, 2, 2, 5, 5, 5, 5};
    int exp_cnt[12] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    for (int e = 0; e < 12; e++) begin
      src_req = (e < 2) ? (25'h1 << 5) : ((25'h1 << 5) | (25'h1 << 2));
      step();
      chk++; if (a_idx !== 5'(exp_idx[e]) || a_cnt !== 8'(exp_cnt[e]))
        $display("FAIL burst_e%0d got idx=%0d cnt=%0d exp idx=%0d cnt=%0d", e, a_idx, a_cnt, exp_idx[e], exp_cnt[e]); else pass++;
    end
    conflict_clr = 1'b1;
    step();
    conflict_clr = 1'b0;
    chk++; if (a_conf !== 1'b1 || a_cnt !== 8'd1)
      $display("FAIL clr_with_conflict got c=%b cnt=%0d exp 1/1", a_conf, a_cnt); else pass++;
    src_req = '0;
    step();
  endtask

  task automatic test_round_robin();
    int exp_idx[6] = '{0, 1, 4, 0, 1, 4};
    clear = 1'b1; src_req = '0;
    step();
    clear = 1'b0; src_req = 25'h0000_0013;
    for (int e = 0; e < 6; e++) begin
      step();
      chk++; if (b_idx !== 5'(exp_idx[e]) || b_valid !== 1'b1)
        $display("FAIL rr_e%0d got idx=%0d v=%b exp idx=%0d v=1", e, b_idx, b_valid, exp_idx[e]); else pass++;
    end
  endtask

  task automatic test_idle_hold();
    src_data[7*W +: W] = 32'h1234_5678;
    src_req = 25'h1 << 7;
    step();
    chk++; if (a_idx !== 5'd7 || b_idx !== 5'd7 || a_bus !== 32'h1234_5678)
      $display("FAIL grant7 got a_idx=%0d b_idx=%0d a_bus=%h exp 7/7/12345678", a_idx, b_idx, a_bus); else pass++;
    src_req = '0;
    step();
    chk++; if (a_valid !== 1'b0 || a_bus !== 32'h0 || a_grant !== '0)
      $display("FAIL idle_hold0 got v=%b bus=%h grant=%h exp 0/0/0", a_valid, a_bus, a_grant); else pass++;
    chk++; if (b_valid !== 1'b0 || b_bus !== 32'h1234_5678 || b_grant !== '0)
      $display("FAIL idle_hold1 got v=%b bus=%h grant=%h exp 0/12345678/0", b_valid, b_bus, b_grant); else pass++;
  endtask

  task automatic test_clear_mid_burst();
    src_req = 25'h1 << 9;
    step(); step();
    chk++; if (a_idx !== 5'd9 || a_valid !== 1'b1)
      $display("FAIL burst9 got idx=%0d v=%b exp 9/1", a_idx, a_valid); else pass++;
    clear = 1'b1;
    step();
    chk++; if ({a_grant, a_bus, a_valid} !== '0 || {b_grant, b_bus, b_valid} !== '0)
      $display("FAIL mid_clear got a=%h/%h/%b b=%h/%h/%b exp zeros", a_grant, a_bus, a_valid, b_grant, b_bus, b_valid); else pass++;
    clear = 1'b0;
    src_req = (25'h1 << 9) | (25'h1 << 12);
    step();
    chk++; if (b_idx !== 5'd9 || a_idx !== 5'd9)
      $display("FAIL rr_restart got b_idx=%0d a_idx=%0d exp 9/9", b_idx, a_idx); else pass++;
  endtask

  task automatic test_saturation();
    src_req = '0; conflict_clr = 1'b1;
    step();
    conflict_clr = 1'b0;
    src_req = 25'h3;
    repeat (254) step();
    chk++; if (a_cnt !== 8'd254)
      $display("FAIL cnt254 got %0d exp 254", a_cnt); else pass++;
    repeat (46) step();
    chk++; if (a_cnt !== 8'd255 || b_cnt !== 8'd255 || a_conf !== 1'b1)
      $display("FAIL cnt_sat got a=%0d b=%0d c=%b exp 255/255/1", a_cnt, b_cnt, a_conf); else pass++;
    src_req = '0; conflict_clr = 1'b1;
    step();
    conflict_clr = 1'b0;
    chk++; if (a_cnt !== 8'd0 || a_conf !== 1'b0 || b_cnt !== 8'd0)
      $display("FAIL cnt_clr got a=%0d c=%b b=%0d exp 0/0/0", a_cnt, a_conf, b_cnt); else pass++;
  endtask

  initial begin
    clear = 1'b1; src_req = '0; conflict_clr = 1'b0;
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'hA000_0000 | 32'(i);
    test_reset();
    test_single();
    test_burst();
    test_round_robin();
    test_idle_hold();
    test_clear_mid_burst();
    test_saturation();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
Parametrised, registered successor to the datapath bus multiplexer. It accepts NUM_SRC request lines instead of assuming one-hot *out strobes. It arbitrates among them by fixed priority or round-robin, and drives the selected source's word onto a registered bus with one cycle of latency. It adds burst hold, starvation limiting and conflict logging. It sits between the register file, special registers and control unit, and feeds every *in-enabled register.

Parameters:
WIDTH, 32, bus word width in bits
NUM_SRC, 25, number of bus sources (index 0 = highest fixed priority)
MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
HOLD_MAX, 4, max consecutive grant cycles for one owner while others wait (range 1..255)
IDLE_HOLD, 0, 0 = bus_out forced to 0 when no grant, 1 = bus_out keeps last value

Ports:
clock  input  1  system clock, rising edge
clear  input  1  synchronous active-high reset
src_data  input  NUM_SRC*WIDTH  packed source words; source i occupies bits [i*WIDTH +: WIDTH]
src_req  input  NUM_SRC  per-source bus request
conflict_clr  input  1  clears conflict flag and counter
grant  output  NUM_SRC  registered one-hot grant, all zero when idle
grant_idx  output  $clog2(NUM_SRC)  index of the current owner, valid when bus_valid = 1
bus_out  output  WIDTH  registered bus word
bus_valid  output  1  bus_out carries the granted source's data
conflict  output  1  sticky flag: more than one request seen in a single cycle
conflict_cnt  output  8  number of multi-request cycles, saturates at 255

Behaviour:
- One clock domain; all state updates on the rising clock edge; clear is synchronous and active-high.
- Reset values when clear = 1:
  - grant = 0, grant_idx = 0, bus_out = 0, bus_valid = 0
  - conflict = 0, conflict_cnt = 0
  - rr_ptr = NUM_SRC-1, so index 0 wins first in round-robin
  - hold_cnt = 0
- clear overrides every other input in the same cycle. A burst in progress is abandoned and no grant survives.
- Latency:
  - src_req and src_data are sampled at edge t.
  - grant, grant_idx, bus_out and bus_valid reflect that arbitration after edge t.
  - bus_out holds the winner's src_data as sampled at edge t. It does not track src_data changes after the edge.
- Arbitration each cycle when src_req != 0:
  - Hold: if the current owner still requests and hold_cnt < HOLD_MAX, the owner keeps the grant. hold_cnt increments, saturating at HOLD_MAX.
  - Yield: if the owner requests, hold_cnt = HOLD_MAX, and any other request is pending, the owner is excluded from this cycle's pick. hold_cnt resets to 1 for the new owner.
  - If the owner requests, hold_cnt = HOLD_MAX, and no other request is pending, the owner keeps the grant and hold_cnt stays at HOLD_MAX.
  - Fixed mode: the lowest-index eligible requester wins.
  - Round-robin mode: the first eligible requester searching rr_ptr+1, rr_ptr+2, … wins, wrapping modulo NUM_SRC. rr_ptr updates to the winner's index on each new grant.
  - New owner: hold_cnt = 1.
- Idle (src_req = 0):
  - grant = 0, bus_valid = 0, hold_cnt = 0.
  - rr_ptr is unchanged.
  - bus_out = 0 if IDLE_HOLD = 0, otherwise the last value.
- An owner dropping its request frees the bus that cycle; arbitration runs among the remaining requesters with no dead cycle.
- Conflict logging:
  - Any cycle with popcount(src_req) >= 2 sets conflict = 1 and increments conflict_cnt, saturating at 255.
  - conflict_clr zeroes both. If a conflict occurs in the same cycle as conflict_clr, the result is conflict = 1, conflict_cnt = 1.
- Invariants checked by assertion:
  - grant is one-hot or zero.
  - bus_valid == |grant.
  - grant_idx matches grant when bus_valid = 1.
- With MODE = 0, HOLD_MAX >= 255 and exactly one request per cycle, the block reproduces the legacy bus output delayed by one cycle.

Decomposition:
- Package bus_pkg holds:
  - MODE_FIXED = 0 and MODE_RR = 1
  - a default-width constant (32)
  - the legacy source index map: PC = 0, ZHIGH = 1, ZLOW = 2, MDR = 3, R0..R15 = 4..19, HI = 20, LO = 21, Y = 22, INPORT = 23, CSIGN = 24
- Sub-module rr_priority_pick:
  - Combinational.
  - Inputs: request vector, start pointer, exclude mask.
  - Outputs: one-hot winner and its index.
  - Fixed mode drives it with start = NUM_SRC-1.

Test Plan:
- Reset with src_req = all ones held → all outputs 0 while clear = 1. First cycle after release: grant[0] = 1, grant_idx = 0, bus_valid = 1, bus_out = src_data[0].
- Fixed mode, src_req[3] alone, src_data[3] = 32'hDEADBEEF → one cycle later bus_out = 32'hDEADBEEF, grant = 1<<3, conflict = 0.
- Fixed mode, HOLD_MAX = 4, src_req[5] and src_req[2] both held high, request 2 raised 2 cycles after request 5 → source 5 owns for 4 cycles, then source 2 owns for 4, alternating. conflict = 1, conflict_cnt counts every overlap cycle.
- Round-robin mode, src_req = 25'h0000_0013 (sources 0, 1, 4) held with HOLD_MAX = 1 → grant_idx sequence 0, 1, 4, 0, 1, 4.
- IDLE_HOLD = 0 vs 1: grant source 7 (data 32'h12345678), then drop all requests → bus_valid = 0 and bus_out = 0 (IDLE_HOLD = 0) or 32'h12345678 (IDLE_HOLD = 1).
- Assert clear mid-burst (source 9 owning, hold_cnt = 2) with src_req still high → outputs zero on that edge. After clear drops, round-robin restarts from index 0. Drive 300 conflict cycles → conflict_cnt saturates at 255; conflict_clr then gives 0.
